axi_chan_buf: RTL and testbench
===============================

// Module: axi_chan_buf
// PURPOSE
//  Parametrised valid/ready buffer for one AXI/APB-style channel (A, W, B or R payload packed into a vector).
//  Decouples a channel SRC from its DST with DEPTH entries of storage, giving full-throughput back-pressure.
//  Selectable latency mode: registered output, or fall-through bypass when empty.
//  Sits between a channel SRC modport and a DST modport. Typical uses: AW/AR/W/R/B slices in bridges and interconnect.
// PARAMETERS
//  DATA_W       64  payload width in bits (e.g. {id,addr,len,size,burst} for A; {id,data,strb,last} for W)
//  DEPTH        4   number of storage entries; power of two, >= 2
//  FALLTHROUGH  0   0: registered output, 1-cycle latency; 1: zero-latency bypass when empty
// PORTS
//  clk          in   1                   channel clock
//  rst_n        in   1                   asynchronous, active-low reset
//  src_valid    in   1                   upstream payload valid
//  src_ready    out  1                   buffer can accept (registered)
//  src_data     in   DATA_W              upstream payload
//  dst_valid    out  1                   downstream payload valid
//  dst_ready    in   1                   downstream accepts
//  dst_data     out  DATA_W              downstream payload
//  occ          out  $clog2(DEPTH)+1     entries held (only with AXI_CHAN_BUF_OCC_EN)
// BEHAVIOUR
//  - Clock and reset: single clock; asynchronous, active-low reset.
//  - Pointers: wptr and rptr are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
//    - empty = (wptr == rptr).
//    - full = index bits equal and MSB differs.
//  - Transfer rules:
//    - push = src_valid & src_ready.
//    - pop = dst_valid & dst_ready.
//    - Push and pop in the same cycle are both honoured; the count is unchanged.
//  - src_ready is a flop. It depends only on the next-state count, never combinationally on dst_ready or src_valid.
//    - Next-cycle value = !(count_next == DEPTH).
//    - When full, a pop in cycle N raises src_ready in N+1 (1-cycle bubble; intended).
//  - FALLTHROUGH=0:
//    - dst_valid = !empty.
//    - dst_data = mem[rptr].
//    - An entry pushed at edge N is visible at dst from edge N.
//  - FALLTHROUGH=1:
//    - dst_valid = !empty | (src_valid & src_ready).
//    - dst_data = empty ? src_data : mem[rptr].
//    - Empty & push & dst_ready: the beat bypasses storage; no write, pointers are held.
//    - Empty & push & !dst_ready: the beat is written normally.
//  - AXI stability: once dst_valid is asserted it stays high, with dst_data stable, until pop.
//    - In FALLTHROUGH=1 this relies on SRC obeying the same rule.
//  - Reset (rst_n low), taking effect immediately (async):
//    - wptr = rptr = 0.
//    - dst_valid = 0.
//    - src_ready = 0.
//    - occ = 0.
//    - Storage is not reset.
//    - dst_data is don't-care while dst_valid = 0; the bench must not check it.
//  - After reset release: src_ready rises at the first posedge with rst_n high.
//  - Reset mid-burst: all held entries are discarded. No partial beat is emitted after release.
//  - Illegal: src_valid dropping before its handshake is a SRC protocol error. It is flagged by a simulation-only assertion, not corrected.
//  - Assertions (translate_off): no push when full; no pop when empty; dst_data stable while dst_valid & !dst_ready.
// CONFIGURATION
//  - AXI_CHAN_BUF_OCC_EN defined:
//    - The occ port exists.
//    - occ = wptr - rptr (modulo 2^($clog2(DEPTH)+1)), registered, range 0..DEPTH.
//    - A bypassed beat never counts.
//  - AXI_CHAN_BUF_OCC_EN undefined:
//    - The occ port is absent.
//    - Internal behaviour is identical.
// TESTING
//  1. Reset, DEPTH=4, FALLTHROUGH=0:
//     - rst_n low -> src_ready=0, dst_valid=0.
//     - Release -> src_ready=1 one edge later.
//  2. Fill, DST stalled (dst_ready=0): push 0xA0..0xA3 -> src_ready=0 after the 4th beat; occ=4.
//  3. Drain: set dst_ready=1 -> dst_data 0xA0,0xA1,0xA2,0xA3 in order on consecutive cycles; then dst_valid=0, occ=0.
//  4. Streaming (src_valid=1, dst_ready=1, 16 beats 0..15):
//     - 1 beat/cycle, first out 1 cycle after first push, order preserved.
//     - occ stays 1.
//  5. FALLTHROUGH=1, empty: push 0x55 with dst_ready=1 -> dst_valid=1, dst_data=0x55 in the same cycle; occ stays 0.
//  6. Reset mid-operation: 3 entries held, pulse rst_n low -> dst_valid=0 immediately; after release no stale beat appears, occ=0.

Source files
------------

// File: rtl/axi_chan_buf.sv
// Valid/ready channel buffer holding DEPTH entries. FALLTHROUGH=1 lets a beat bypass storage when empty.
// Define AXI_CHAN_BUF_OCC_EN to expose the registered occupancy port occ.
module axi_chan_buf #(
    parameter int DATA_W      = 64,
    parameter int DEPTH       = 4,
    parameter int FALLTHROUGH = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    src_valid,
    output logic                    src_ready,
    input  logic [DATA_W-1:0]       src_data,
    output logic                    dst_valid,
    input  logic                    dst_ready,
    output logic [DATA_W-1:0]       dst_data
`ifdef AXI_CHAN_BUF_OCC_EN
    ,
    output logic [$clog2(DEPTH):0]  occ
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr, rptr, count, count_next;
    logic              empty, full, push, pop, bypass, wr_en, rd_en;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign count = wptr - rptr;
    assign push  = src_valid & src_ready;
    assign pop   = dst_valid & dst_ready;

    generate
        if (FALLTHROUGH != 0) begin : g_ft
            assign bypass    = empty & push & dst_ready;
            assign dst_valid = !empty | push;
            assign dst_data  = empty ? src_data : mem[rptr[AW-1:0]];
        end else begin : g_reg
            assign bypass    = 1'b0;
            assign dst_valid = !empty;
            assign dst_data  = mem[rptr[AW-1:0]];
        end
    endgenerate

    // A bypassed beat is both pushed and popped without touching storage or pointers.
    assign wr_en = push & ~bypass;
    assign rd_en = pop & ~bypass;

    always_comb begin
        count_next = count + PW'(wr_en) - PW'(rd_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            src_ready <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + PW'(1);
            if (rd_en) rptr <= rptr + PW'(1);
            src_ready <= (count_next != PW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= src_data;
    end

`ifdef AXI_CHAN_BUF_OCC_EN
    assign occ = count;
`endif

`ifndef SYNTHESIS
    logic              hold_q, src_wait_q;
    logic [DATA_W-1:0] hold_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= 1'b0;
            src_wait_q <= 1'b0;
        end else begin
            assert (!(push && full));
            assert (!(rd_en && empty));
            if (hold_q) assert (dst_valid && (dst_data == hold_data_q));
            if (src_wait_q) assert (src_valid);
            hold_q     <= dst_valid & ~dst_ready;
            src_wait_q <= src_valid & ~src_ready;
        end
    end

    always_ff @(posedge clk) begin
        hold_data_q <= dst_data;
    end
`endif
endmodule

// File: tb/tb_axi_chan_buf.sv
// Bench for axi_chan_buf: one registered and one fall-through instance share stimulus and are
// checked every cycle against queue models, plus directed literal checks.
module tb_axi_chan_buf;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk, rst_n, src_valid, dst_ready;
    logic [DW-1:0] src_data;
    logic          src_ready0, dst_valid0, src_ready1, dst_valid1;
    logic [DW-1:0] dst_data0, dst_data1;
`ifdef AXI_CHAN_BUF_OCC_EN
    logic [2:0]    occ0, occ1;
`endif

    int total = 0;
    int bad   = 0;

    axi_chan_buf #(.DATA_W(DW), .DEPTH(DEPTH), .FALLTHROUGH(0)) u_reg (
        .clk(clk), .rst_n(rst_n),
        .src_valid(src_valid), .src_ready(src_ready0), .src_data(src_data),
        .dst_valid(dst_valid0), .dst_ready(dst_ready), .dst_data(dst_data0)
`ifdef AXI_CHAN_BUF_OCC_EN
        , .occ(occ0)
`endif
    );

    axi_chan_buf #(.DATA_W(DW), .DEPTH(DEPTH), .FALLTHROUGH(1)) u_ft (
        .clk(clk), .rst_n(rst_n),
        .src_valid(src_valid), .src_ready(src_ready1), .src_data(src_data),
        .dst_valid(dst_valid1), .dst_ready(dst_ready), .dst_data(dst_data1)
`ifdef AXI_CHAN_BUF_OCC_EN
        , .occ(occ1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: stored beats as queues, src_ready as a plain flag.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    bit rdy0 = 1'b0, rdy1 = 1'b0, pend0 = 1'b0, pend1 = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit p, e, dv;
        if (!rst_n) begin
            q0.delete(); q1.delete();
            rdy0 = 1'b0; rdy1 = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
        end else begin
            p = src_valid && rdy0;
            e = (q0.size() == 0);
            pend0 = src_valid && !rdy0;
            if (!e && dst_ready) void'(q0.pop_front());
            if (p) q0.push_back(src_data);
            rdy0 = (q0.size() != DEPTH);

            p = src_valid && rdy1;
            e = (q1.size() == 0);
            dv = !e || p;
            pend1 = src_valid && !rdy1;
            if (!(e && p && dst_ready)) begin
                if (dv && dst_ready) void'(q1.pop_front());
                if (p) q1.push_back(src_data);
            end
            rdy1 = (q1.size() != DEPTH);
        end
    end

    always @(negedge clk) begin
        bit e1, edv1;
        #2;
        chk("m_src_ready0", src_ready0, rdy0);
        chk("m_dst_valid0", dst_valid0, q0.size() != 0);
        if (q0.size() != 0) chk("m_dst_data0", dst_data0, q0[0]);
        e1   = (q1.size() == 0);
        edv1 = !e1 || (src_valid && rdy1);
        chk("m_src_ready1", src_ready1, rdy1);
        chk("m_dst_valid1", dst_valid1, edv1);
        if (edv1) chk("m_dst_data1", dst_data1, e1 ? src_data : q1[0]);
`ifdef AXI_CHAN_BUF_OCC_EN
        chk("m_occ0", occ0, q0.size());
        chk("m_occ1", occ1, q1.size());
`endif
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; src_valid = 1'b0; src_data = '0; dst_ready = 1'b0;

        repeat (2) @(negedge clk);
        #2;
        chk("rst_src_ready", src_ready0, 0);
        chk("rst_dst_valid", dst_valid0, 0);
        chk("rst_dst_valid_ft", dst_valid1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("rel_src_ready_pre", src_ready0, 0);
        @(posedge clk);
        #1;
        chk("rel_src_ready_post", src_ready0, 1);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            src_valid = 1'b1; src_data = DW'(8'hA0 + i); dst_ready = 1'b0;
        end
        @(negedge clk);
        src_valid = 1'b0;
        #2;
        chk("fill_src_ready", src_ready0, 0);
        chk("fill_src_ready_ft", src_ready1, 0);
        chk("fill_head", dst_data0, 8'hA0);
`ifdef AXI_CHAN_BUF_OCC_EN
        chk("fill_occ", occ0, 4);
`endif

        @(negedge clk);
        dst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("drain_valid", dst_valid0, 1);
            chk("drain_data", dst_data0, 32'(8'hA0 + k));
            @(negedge clk);
        end
        #2;
        chk("drain_empty", dst_valid0, 0);
`ifdef AXI_CHAN_BUF_OCC_EN
        chk("drain_occ", occ0, 0);
`endif

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            src_valid = 1'b1; src_data = DW'(i); dst_ready = 1'b1;
            #2;
            if (i == 0) chk("stream_first_valid", dst_valid0, 0);
            else begin
                chk("stream_valid", dst_valid0, 1);
                chk("stream_data", dst_data0, i - 1);
`ifdef AXI_CHAN_BUF_OCC_EN
                chk("stream_occ", occ0, 1);
`endif
            end
            chk("stream_ft_data", dst_data1, i);
        end
        @(negedge clk);
        src_valid = 1'b0;
        #2;
        chk("stream_last", dst_data0, 15);
        @(negedge clk);
        #2;
        chk("stream_done", dst_valid0, 0);

        @(negedge clk);
        src_valid = 1'b1; src_data = 8'h55; dst_ready = 1'b1;
        #2;
        chk("ft_bypass_valid", dst_valid1, 1);
        chk("ft_bypass_data", dst_data1, 8'h55);
`ifdef AXI_CHAN_BUF_OCC_EN
        chk("ft_bypass_occ", occ1, 0);
`endif
        @(negedge clk);
        src_valid = 1'b0;
        #2;
        chk("ft_bypass_after", dst_valid1, 0);
        chk("reg_after_bypass", dst_data0, 8'h55);

        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            src_valid = 1'b1; src_data = DW'(8'hB0 + i); dst_ready = 1'b0;
        end
        @(negedge clk);
        src_valid = 1'b0;
        #2;
        chk("mid_held_valid", dst_valid0, 1);
`ifdef AXI_CHAN_BUF_OCC_EN
        chk("mid_held_occ", occ0, 3);
`endif
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", dst_valid0, 0);
        chk("mid_rst_valid_ft", dst_valid1, 0);
        chk("mid_rst_ready", src_ready0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dst_ready = 1'b1;
        @(negedge clk);
        #2;
        chk("mid_rel_valid", dst_valid0, 0);
        chk("mid_rel_ready", src_ready0, 1);
`ifdef AXI_CHAN_BUF_OCC_EN
        chk("mid_rel_occ", occ0, 0);
`endif

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!(pend0 || pend1)) begin
                src_valid = ($urandom_range(0, 9) < 7);
                src_data  = DW'($urandom);
            end
            dst_ready = ($urandom_range(0, 9) < (((n / 300) % 2) != 0 ? 8 : 3));
        end
        @(negedge clk);
        src_valid = 1'b0;
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
